// File: rtl/sha256_multi_block_engine.sv
// SHA-256 engine over a word-aligned message in external single-port memory.
// Blocks are streamed and padded on the fly; an optional second pass gives SHA256(SHA256(m)).
module sha256_multi_block_engine #(
   parameter  int MAX_WORDS = 64,
   parameter  int ADDR_W    = 16,
   localparam int LW        = $clog2(MAX_WORDS + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              double_hash,
   input  logic [LW-1:0]     msg_words,
   input  logic [ADDR_W-1:0] message_addr,
   input  logic [ADDR_W-1:0] output_addr,
   output logic              done,
   output logic              error,
   output logic              mem_clk,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_write_data,
   input  logic [31:0]       mem_read_data
);
   // state   | meaning
   // IDLE    | waiting for start, done high
   // LOAD    | fill w[0..15] from memory / pad words, {a..h} := H
   // COMPUTE | 64 compression rounds
   // UPDATE  | H += {a..h}, pick next block, second pass or write-back
   // WRITE   | 8 digest words to output_addr..+7
   localparam int PW = LW + 4;

   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
   localparam logic [31:0] IV [0:7] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, UPDATE, WRITE} state_t;
   state_t state;

   logic              dbl_q, pass, rd1, rd2;
   logic [LW-1:0]     len_q, nb, blk, nb_in;
   logic [ADDR_W-1:0] maddr_q, oaddr_q, iss_base, iss_addr;
   logic [4:0]        cnt;
   logic [5:0]        rnd;
   logic [2:0]        wk;
   logic [31:0]       pad1, pad2, cap, t1, t2, sched;
   logic [31:0]       h [8];
   logic [31:0]       hn [8];
   logic [31:0]       v [8];
   logic [31:0]       w [16];
   logic [PW-1:0]     iss_p;
   logic [LW-1:0]     iss_len, iss_nb;
   logic              iss_en;
   logic [32:0]       slot_v;

   assign mem_clk = clk;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int s);
      return (x >> s) | (x << (32 - s));
   endfunction

   // {read needed, pad value} for global padded word p
   function automatic logic [32:0] slot_fn(input logic [PW-1:0] p, input logic [LW-1:0] len,
                                           input logic [LW-1:0] nbv);
      logic [PW-1:0] last;
      last = {nbv, 4'b0} - PW'(1);
      if (PW'(len) > p)       return {1'b1, 32'h0};
      else if (PW'(len) == p) return {1'b0, 32'h80000000};
      else if (p == last)     return {1'b0, 32'(len) << 5};
      else                    return 33'h0;
   endfunction

   always_comb begin
      for (int i = 0; i < 8; i++) hn[i] = h[i] + v[i];
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[rnd] + w[0];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      sched = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
            + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
      cap   = rd2 ? mem_read_data : pad2;
      nb_in = LW'(({1'b0, msg_words} + (LW+1)'(2)) >> 4) + LW'(1);

      iss_p    = '0;
      iss_len  = len_q;
      iss_nb   = nb;
      iss_base = maddr_q;
      iss_en   = 1'b0;
      case (state)
         IDLE: begin
            iss_len  = msg_words;
            iss_nb   = nb_in;
            iss_base = message_addr;
            iss_en   = start && (msg_words <= LW'(MAX_WORDS));
         end
         LOAD: begin
            iss_p  = {blk, cnt[3:0] + 4'd1};
            iss_en = !pass && (cnt < 5'd15);
         end
         UPDATE: begin
            iss_p  = {blk + LW'(1), 4'd0};
            iss_en = (blk + LW'(1)) < nb;
         end
         default: ;
      endcase
      slot_v   = slot_fn(iss_p, iss_len, iss_nb);
      iss_addr = iss_base + ADDR_W'(iss_p);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;  done <= 1'b1;  error <= 1'b0;
         mem_we <= 1'b0;  mem_addr <= '0;  mem_write_data <= '0;
         dbl_q <= 1'b0;  pass <= 1'b0;  rd1 <= 1'b0;  rd2 <= 1'b0;
         len_q <= '0;  nb <= '0;  blk <= '0;  maddr_q <= '0;  oaddr_q <= '0;
         cnt <= '0;  rnd <= '0;  wk <= '0;  pad1 <= '0;  pad2 <= '0;
         for (int i = 0; i < 8; i++) begin h[i] <= '0; v[i] <= '0; end
         for (int i = 0; i < 16; i++) w[i] <= '0;
      end else begin
         error <= 1'b0;
         rd2   <= rd1;
         pad2  <= pad1;
         case (state)
            IDLE: if (start) begin
               if (msg_words > LW'(MAX_WORDS)) error <= 1'b1;
               else begin
                  dbl_q <= double_hash;  len_q <= msg_words;  nb <= nb_in;
                  maddr_q <= message_addr;  oaddr_q <= output_addr;
                  for (int i = 0; i < 8; i++) h[i] <= IV[i];
                  blk <= '0;  pass <= 1'b0;  cnt <= '0;  done <= 1'b0;
                  state <= LOAD;
               end
            end
            LOAD: begin
               for (int i = 0; i < 8; i++) v[i] <= h[i];
               if (pass) begin
                  rnd <= '0;  state <= COMPUTE;
               end else begin
                  // slot cnt captures the word whose address went out during slot cnt-1
                  if (cnt != 5'd0) begin
                     for (int i = 0; i < 15; i++) w[i] <= w[i+1];
                     w[15] <= cap;
                  end
                  if (cnt == 5'd16) begin
                     rnd <= '0;  state <= COMPUTE;
                  end
                  cnt <= cnt + 5'd1;
               end
            end
            COMPUTE: begin
               v[0] <= t1 + t2;  v[1] <= v[0];  v[2] <= v[1];  v[3] <= v[2];
               v[4] <= v[3] + t1;  v[5] <= v[4];  v[6] <= v[5];  v[7] <= v[6];
               for (int i = 0; i < 15; i++) w[i] <= w[i+1];
               w[15] <= sched;
               rnd <= rnd + 6'd1;
               if (rnd == 6'd63) state <= UPDATE;
            end
            UPDATE: begin
               for (int i = 0; i < 8; i++) h[i] <= hn[i];
               if ((blk + LW'(1)) < nb) begin
                  blk <= blk + LW'(1);  cnt <= '0;  state <= LOAD;
               end else if (!pass && dbl_q) begin
                  for (int i = 0; i < 8; i++) begin h[i] <= IV[i]; w[i] <= hn[i]; end
                  w[8] <= 32'h80000000;
                  for (int i = 9; i < 15; i++) w[i] <= '0;
                  w[15] <= 32'd256;
                  pass <= 1'b1;  blk <= '0;  nb <= LW'(1);  state <= LOAD;
               end else begin
                  mem_we <= 1'b1;  mem_addr <= oaddr_q;  mem_write_data <= hn[0];
                  wk <= '0;  state <= WRITE;
               end
            end
            WRITE: begin
               if (wk == 3'd7) begin
                  mem_we <= 1'b0;  done <= 1'b1;  state <= IDLE;
               end else begin
                  mem_addr       <= oaddr_q + ADDR_W'(wk) + ADDR_W'(1);
                  mem_write_data <= h[3'(wk + 3'd1)];
                  wk             <= wk + 3'd1;
               end
            end
            default: state <= IDLE;
         endcase
         if (iss_en) begin
            if (slot_v[32]) mem_addr <= iss_addr;
            rd1  <= slot_v[32];
            pad1 <= slot_v[31:0];
         end
      end
   end
endmodule

// File: tb/tb_sha256_multi_block_engine.sv
// Directed + randomized bench for sha256_multi_block_engine against a plain software SHA-256 model.
module tb_sha256_multi_block_engine;
   typedef logic [31:0] wq_t[$];

   logic        clk = 1'b0;
   logic        reset, start, double_hash;
   logic [6:0]  msg_words;
   logic [15:0] message_addr, output_addr;
   logic        done, error, mem_clk, mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_write_data, mem_read_data, rdata;

   logic [31:0] mem_model [0:65535];
   logic [63:0] wr_q[$];
   int          reads, addr_bad, cur_len;
   logic [15:0] cur_ma, last_addr = 16'h0;
   bit          mon_on = 1'b0;
   int          checks = 0, errors = 0;

   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
   localparam logic [31:0] IV [0:7] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   localparam logic [255:0] D_EMPTY  = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
   localparam logic [255:0] D_EMPTY2 = 256'h5df6e0e2_761359d3_0a827505_8e299fcc_03815345_45f55cf4_3e41983f_5d4c9456;
   localparam logic [255:0] D_ZERO16 = 256'hf5a5fd42_d16a2030_2798ef6e_d309979b_43003d23_20d9f0e8_ea9831a9_2759fb4b;

   sha256_multi_block_engine #(.MAX_WORDS(64), .ADDR_W(16)) dut (
      .clk(clk), .reset(reset), .start(start), .double_hash(double_hash),
      .msg_words(msg_words), .message_addr(message_addr), .output_addr(output_addr),
      .done(done), .error(error), .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data));

   always #5 clk = ~clk;

   // memory: data for the address presented in one cycle appears in the next
   always @(posedge clk) rdata <= mem_model[mem_addr];
   assign mem_read_data = rdata;

   always @(negedge clk) begin
      if (mon_on) begin
         if (mem_we) wr_q.push_back({16'h0, mem_addr, mem_write_data});
         else if (mem_addr !== last_addr) begin
            reads++;
            if (int'(16'(mem_addr - cur_ma)) >= cur_len) addr_bad++;
         end
      end
      last_addr = mem_addr;
   end

   function automatic logic [31:0] rotr(input logic [31:0] x, input int s);
      return (x >> s) | (x << (32 - s));
   endfunction

   function automatic logic [255:0] sha_ref(input wq_t msg);
      wq_t p;
      logic [31:0] hh [8];
      logic [31:0] W [64];
      logic [31:0] a, b, c, d, e, f, g, h, x1, x2, s0, s1;
      logic [255:0] r;
      int n;
      n = msg.size();
      p = msg;
      p.push_back(32'h80000000);
      while (p.size() % 16 != 14) p.push_back(32'h0);
      p.push_back(32'h0);
      p.push_back(32'(n * 32));
      for (int i = 0; i < 8; i++) hh[i] = IV[i];
      for (int bi = 0; bi < p.size() / 16; bi++) begin
         for (int t = 0; t < 64; t++) begin
            if (t < 16) W[t] = p[16*bi + t];
            else begin
               s0 = rotr(W[t-15], 7) ^ rotr(W[t-15], 18) ^ (W[t-15] >> 3);
               s1 = rotr(W[t-2], 17) ^ rotr(W[t-2], 19) ^ (W[t-2] >> 10);
               W[t] = W[t-16] + s0 + W[t-7] + s1;
            end
         end
         a = hh[0]; b = hh[1]; c = hh[2]; d = hh[3]; e = hh[4]; f = hh[5]; g = hh[6]; h = hh[7];
         for (int t = 0; t < 64; t++) begin
            x1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + W[t];
            x2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + x1; d = c; c = b; b = a; a = x1 + x2;
         end
         hh[0] += a; hh[1] += b; hh[2] += c; hh[3] += d;
         hh[4] += e; hh[5] += f; hh[6] += g; hh[7] += h;
      end
      for (int k = 0; k < 8; k++) r[255 - 32*k -: 32] = hh[k];
      return r;
   endfunction

   function automatic wq_t mem_msg(input logic [15:0] ma, input int len);
      wq_t q;
      for (int i = 0; i < len; i++) q.push_back(mem_model[16'(ma + 16'(i))]);
      return q;
   endfunction

   function automatic logic [255:0] ref_digest(input logic [15:0] ma, input int len, input bit dbl);
      logic [255:0] d1;
      wq_t q;
      d1 = sha_ref(mem_msg(ma, len));
      if (!dbl) return d1;
      for (int k = 0; k < 8; k++) q.push_back(d1[255 - 32*k -: 32]);
      return sha_ref(q);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // called at a negedge; returns at a negedge with the engine back in IDLE
   task automatic run_hash(input string tag, input int len, input bit dbl,
                           input logic [15:0] ma, input logic [15:0] oa, input logic [255:0] exp);
      int lat, n, nblk;
      wr_q.delete();
      reads = 0; addr_bad = 0; cur_ma = ma; cur_len = len; mon_on = 1'b1;
      start = 1'b1; double_hash = dbl; msg_words = 7'(len); message_addr = ma; output_addr = oa;
      @(negedge clk);
      start = 1'b0; double_hash = 1'($urandom); message_addr = 16'($urandom); output_addr = 16'($urandom);
      chk({tag, "_done_low"}, 64'(done), 64'd0);
      lat = 0;
      while (!mem_we && lat < 2000) begin @(negedge clk); lat++; end
      n = 0;
      while (!done && n < 40) begin @(negedge clk); n++; end
      mon_on = 1'b0;
      chk({tag, "_done_back"}, 64'(done), 64'd1);
      nblk = (len + 3 + 15) / 16 + (dbl ? 1 : 0);
      chk({tag, "_lat_max"}, 64'(lat <= 82 * nblk), 64'd1);
      chk({tag, "_lat_min"}, 64'(lat > 64 * nblk), 64'd1);
      chk({tag, "_nwrites"}, 64'(wr_q.size()), 64'd8);
      for (int k = 0; k < 8 && k < wr_q.size(); k++)
         chk($sformatf("%s_wr%0d", tag, k), wr_q[k], {16'h0, 16'(oa + 16'(k)), exp[255 - 32*k -: 32]});
      chk({tag, "_reads"}, 64'(reads), 64'(len));
      chk({tag, "_addr_range"}, 64'(addr_bad), 64'd0);
   endtask

   initial begin
      int n, len;
      bit dbl;
      logic [15:0] ma_s;
      reset = 1'b1; start = 1'b0; double_hash = 1'b0; msg_words = '0;
      message_addr = '0; output_addr = '0;
      for (int i = 0; i < 65536; i++) mem_model[i] = $urandom;
      repeat (2) @(negedge clk);
      chk("rst_done", 64'(done), 64'd1);
      chk("rst_error", 64'(error), 64'd0);
      chk("rst_we", 64'(mem_we), 64'd0);
      chk("rst_addr", 64'(mem_addr), 64'd0);
      chk("rst_wdata", 64'(mem_write_data), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      run_hash("empty", 0, 1'b0, 16'h1000, 16'h2000, D_EMPTY);
      run_hash("empty_dbl", 0, 1'b1, 16'h1000, 16'h2100, D_EMPTY2);
      for (int i = 0; i < 16; i++) mem_model[16'h3000 + i] = 32'h0;
      run_hash("zero16", 16, 1'b0, 16'h3000, 16'h2200, D_ZERO16);
      run_hash("len14", 14, 1'b0, 16'h4000, 16'h2300, ref_digest(16'h4000, 14, 1'b0));
      run_hash("len13", 13, 1'b0, 16'h5000, 16'h2310, ref_digest(16'h5000, 13, 1'b0));
      run_hash("max_wrap_dbl", 64, 1'b1, 16'hfff0, 16'h2400, ref_digest(16'hfff0, 64, 1'b1));
      for (int i = 0; i < 3; i++) begin
         len  = $urandom_range(1, 63);
         dbl  = 1'($urandom);
         ma_s = 16'h6000 + 16'(i * 256);
         run_hash($sformatf("rand%0d", i), len, dbl, ma_s, 16'h2500 + 16'(i * 16), ref_digest(ma_s, len, dbl));
      end

      // oversize request: one-cycle error, no memory activity, done stays high
      ma_s = mem_addr;
      start = 1'b1; msg_words = 7'd65; message_addr = 16'h7000; output_addr = 16'h7100;
      @(negedge clk);
      start = 1'b0;
      chk("err_pulse", 64'(error), 64'd1);
      chk("err_done", 64'(done), 64'd1);
      @(negedge clk);
      chk("err_one_cycle", 64'(error), 64'd0);
      n = 0;
      repeat (10) begin
         @(negedge clk);
         if (mem_we !== 1'b0 || mem_addr !== ma_s || done !== 1'b1) n++;
      end
      chk("err_quiet", 64'(n), 64'd0);

      // start together with reset: reset wins
      reset = 1'b1; start = 1'b1; msg_words = 7'd0;
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      repeat (2) @(negedge clk);
      chk("start_rst_done", 64'(done), 64'd1);
      chk("start_rst_we", 64'(mem_we), 64'd0);

      // reset during write-back at k=3
      start = 1'b1; double_hash = 1'b0; msg_words = 7'd0; message_addr = 16'h1000; output_addr = 16'h2700;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!(mem_we === 1'b1 && mem_addr === 16'h2703) && n < 300) begin @(negedge clk); n++; end
      chk("wr3_reached", 64'(mem_we === 1'b1 && mem_addr === 16'h2703), 64'd1);
      #1 reset = 1'b1;
      #1;
      chk("midwr_we", 64'(mem_we), 64'd0);
      chk("midwr_done", 64'(done), 64'd1);
      chk("midwr_addr", 64'(mem_addr), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      run_hash("after_rst", 0, 1'b0, 16'h7000, 16'h2600, D_EMPTY);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sha256_multi_block_engine.md
Name: sha256_multi_block_engine

Overview:
- Parametrised SHA-256 engine that hashes a word-aligned message in external memory, of runtime length 0..MAX_WORDS words.
- Optional double-hash mode computes SHA256(SHA256(m)) for the Bitcoin path.
- Streams one 512-bit block at a time from memory (no whole-message buffer), pads on the fly, and writes the 8-word digest back through the shared single-port memory interface.

Parameters:
MAX_WORDS, 64, largest accepted message length in 32-bit words; LW = $clog2(MAX_WORDS+1).
ADDR_W, 16, memory word-address width.

Ports:
clk  in  1  system clock; also driven out as mem_clk.
reset  in  1  asynchronous, active-high reset.
start  in  1  one-cycle request; sampled only in IDLE.
double_hash  in  1  sampled with start; 1 = SHA256(SHA256(m)).
msg_words  in  LW  message length in words, sampled with start.
message_addr  in  ADDR_W  first message word address, sampled with start.
output_addr  in  ADDR_W  digest base address, sampled with start.
done  out  1  high while IDLE.
error  out  1  one-cycle pulse when a start is rejected.
mem_clk  out  1  equals clk.
mem_we  out  1  write enable.
mem_addr  out  ADDR_W  registered address.
mem_write_data  out  32  registered write data.
mem_read_data  in  32  read data, valid the cycle after mem_addr is presented.

Behaviour:
- Reset values: done=1, error=0, mem_we=0, mem_addr=0, mem_write_data=0, state=IDLE. Reset mid-operation aborts immediately, including mid-write; no partial-result guarantee.
- States: IDLE, LOAD, COMPUTE, UPDATE, WRITE.
- IDLE:
  - start with msg_words>MAX_WORDS: error=1 for one cycle, no memory access, stay IDLE.
  - Otherwise latch inputs, H0..H7 := SHA-256 IV, blk := 0, pass := 0, go to LOAD.
  - start while not IDLE is ignored.
- Block count: nb = (msg_words+2)/16 + 1 (integer division).
- Padded word p (global index 16*blk+t):
  - p<msg_words: memory word at message_addr+p.
  - p==msg_words: 32'h80000000.
  - p==16*nb-2: 0, since bit length < 2^32.
  - p==16*nb-1: msg_words*32.
  - Otherwise 0.
- LOAD:
  - Fills w[0..15] over 16 slots; a memory read is issued only for p<msg_words, and pad words are inserted without a read.
  - Read data is captured exactly one cycle after its address.
  - {a..h} := {H0..H7}; exit to COMPUTE after w[15] is captured.
- COMPUTE:
  - Exactly 64 rounds, one per cycle, round t uses K[t].
  - W[t] for t<16 comes from w[t]. For t≥16 it comes from a 16-entry rolling schedule (σ0(w[1])+σ1(w[14])+w[0]+w[9]) that shifts one entry per round.
  - All arithmetic is mod 2^32.
- UPDATE (1 cycle): Hi := Hi + {a..h}[i], then:
  - blk+1<nb: blk++, LOAD.
  - Else if pass==0 and double_hash: second pass. One block with w[0..7] := H0..H7, w[8]=80000000, w[9..14]=0, w[15]=256. H := IV, pass := 1, blk := 0, nb := 1. LOAD makes no memory reads in this pass.
  - Else: WRITE.
- WRITE: 8 consecutive cycles with mem_we=1, mem_addr=output_addr+k, mem_write_data=Hk for k=0..7, then mem_we=0 and return to IDLE.
- Latency per block ≤ 16 (LOAD) + 1 + 64 + 1. done deasserts the cycle after an accepted start.
- Boundaries:
  - msg_words=0 gives 1 block with no reads.
  - msg_words=14 gives 2 blocks, since 0x80000000 lands at word 14 and the length words move to block 2.
  - msg_words=MAX_WORDS is accepted.
  - message_addr+p wraps modulo 2^ADDR_W.
  - Simultaneous start and reset: reset wins.

Test Plan:
- msg_words=0, double_hash=0 → no reads; writes e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855 at output_addr..+7; done returns high.
- msg_words=0, double_hash=1 → writes 5df6e0e2 761359d3 0a827505 8e299fcc 03815345 45f55cf4 3e41983f 5d4c9456.
- msg_words=16, all memory words 0 → exactly 16 reads, 2 blocks, digest f5a5fd42 d16a2030 2798ef6e d309979b 43003d23 20d9f0e8 ea9831a9 2759fb4b.
- msg_words=14 and 13 vs software model → 2 and 1 blocks respectively; digests match the model; check mem_addr never exceeds message_addr+msg_words-1 during LOAD.
- msg_words=MAX_WORDS+1 → error pulses one cycle, mem_we stays 0, no address activity, done stays 1.
- reset asserted during WRITE at k=3 → mem_we=0 and done=1 immediately; a following start with msg_words=0 yields the correct empty-message digest.
